spi_slave_stream: RTL and testbench
===================================

# spi_slave_stream

Parametrised SPI slave for the FPGA controller. It supports all four SPI modes and configurable word width. A single SS_n frame can carry any number of back-to-back words. Received words are buffered in an RX FIFO with a valid/ready pop interface. Transmit words are taken per word from a valid/ready source, with a fixed idle word used on underrun.

## Interface
- DATA_W, 4, bits per SPI word (≥2)
- FIFO_DEPTH, 4, RX FIFO entries (power of 2, ≥2)
- CPOL, 0, SCLK idle level
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
- MSB_FIRST, 1, 1 = MSB first, 0 = LSB first; applies to both MOSI and MISO
- IDLE_TX, 0, DATA_W-bit word sent when no TX word is offered
- clk  in  1  system clock
- reset  in  1  synchronous, active-low (0 = reset)
- sclk_in  in  1  SPI clock, asynchronous
- mosi_in  in  1  SPI data in, asynchronous
- ss_n_in  in  1  SPI select, active-low, asynchronous
- miso_out  out  1  SPI data out (registered)
- rx_data_out  out  DATA_W  FIFO head word; 0 while rx_valid_out = 0
- rx_valid_out  out  1  FIFO not empty
- rx_ready_in  in  1  pop head when rx_valid_out & rx_ready_in
- tx_data_in  in  DATA_W  next word to transmit
- tx_valid_in  in  1  tx_data_in is offered
- tx_ready_out  out  1  one-clk pulse: tx_data_in consumed this cycle
- frame_active_out  out  1  state = ACTIVE
- fifo_level_out  out  $clog2(FIFO_DEPTH)+1  entries held
- overflow_out  out  1  sticky: word dropped because FIFO was full
- frame_err_out  out  1  sticky: SS_n rose with a partial word
- clear_err_in  in  1  clears both sticky flags

## Operation
- Synchroniser: sclk_in, ss_n_in and mosi_in each pass through 2 FFs (sync1, sync2), plus a sync3 history FF for sclk and ss_n.
- Edge detection: an edge is detected when sync2 ≠ sync3.
  - Leading SCLK edge = the transition away from CPOL.
  - Sample edge = leading if CPHA = 0, trailing if CPHA = 1; the shift edge is the other one.
- FSM, state IDLE:
  - Enter ACTIVE on a detected SS_n fall.
  - On entry: bit_cnt = 0, rx shifter = 0, load_pending = CPHA.
  - If CPHA = 0, load the TX shifter on entry.
- FSM, state ACTIVE, sample edge:
  - Shift mosi_sync2 into the rx shifter in MSB_FIRST order; bit_cnt++.
  - At bit_cnt = DATA_W−1: push the completed word, set bit_cnt = 0 and load_pending = 1.
- FSM, state ACTIVE, shift edge:
  - If load_pending = 1: load the TX shifter and clear load_pending.
  - Otherwise: shift the TX shifter one bit.
- FSM, state ACTIVE, SS_n rise: return to IDLE.
  - If bit_cnt ≠ 0, set frame_err_out and discard the partial word.
  - miso_out goes to 0.
- SCLK edges are ignored while in IDLE.
- TX load rule:
  - If tx_valid_in = 1: shifter = tx_data_in and tx_ready_out pulses in the same cycle.
  - Otherwise: shifter = IDLE_TX and tx_ready_out stays 0.
  - miso_out = first-order bit of the shifter (MSB if MSB_FIRST, else LSB).
  - miso_out = 0 in IDLE and before the first load when CPHA = 1.
- FIFO:
  - Circular buffer with wrapping pointers.
  - Push when full without a pop in the same cycle: the word is dropped and overflow_out = 1.
  - Push and pop in the same cycle when full: both succeed, level unchanged, no overflow.
  - Pop when empty: ignored.
- Sticky flags:
  - clear_err_in clears both flags.
  - If a set and clear_err_in occur in the same cycle, the set wins.
- Reset (any cycle, including mid-frame):
  - FSM goes to IDLE; FIFO is emptied.
  - All outputs go to 0: miso_out, rx_data_out, rx_valid_out, tx_ready_out, frame_active_out, fifo_level_out, overflow_out, frame_err_out.
  - Synchronisers load idle values: sclk = CPOL, ss_n = 1, mosi = 0.

## Timing
- Pin edge at clk edge k:
  - sync1 captures it at k, sync2 at k+1; the event is visible combinationally in the following cycle.
  - All resulting register updates land at clk edge k+2.
- rx_valid_out rises at edge k+2 after the pin edge completing a word.
- rx_data_out and fifo_level_out update at the same edge.
- miso_out changes at edge k+2 after the pin shift edge or SS_n fall.
- tx_ready_out is high for exactly the one cycle ending at the load edge.
- Master requirements:
  - Each SCLK high and low phase ≥ 4 clk periods.
  - SS_n setup to the first SCLK edge ≥ 4 clk.
  - SS_n hold after the last SCLK edge ≥ 4 clk.
- Throughput: one push per DATA_W sample edges; pops accepted every cycle.

## Test plan
- Mode 0, DATA_W = 4, one frame sending 0xA, 0x5, 0xC with rx_ready_in = 1 and tx_valid_in = 1 offering 0x3, 0x9, 0x6:
  - rx_data_out shows 0xA, 0x5, 0xC in order.
  - MISO bitstream is 0011 1001 0110.
  - Three tx_ready_out pulses.
- All four modes (CPOL/CPHA) × MSB_FIRST ∈ {0,1}, one-word frame 0x9, tx_valid_in = 0, IDLE_TX = 0x6:
  - Received word is 0x9.
  - MISO carries 0x6 in the configured bit order.
  - No tx_ready_out pulse.
- FIFO_DEPTH = 4, rx_ready_in = 0, six words sent:
  - fifo_level_out = 4 and overflow_out = 1.
  - Pops return the first four words.
  - clear_err_in clears overflow_out; a full FIFO with simultaneous push and pop gives no overflow.
- SS_n rises after 2 of 4 bits:
  - frame_err_out = 1 and no push.
  - The next frame sending 0xF receives 0xF.
- reset = 0 mid-word with 2 words queued:
  - Next cycle all outputs are 0 and fifo_level_out = 0.
  - After reset is released, a full frame sending 0x7 is received correctly.

Source files
------------

// File: rtl/spi_slave_stream.sv
// spi_slave_stream: SPI slave for all four SPI modes. Frames of back-to-back
// DATA_W-bit words are received into an RX FIFO with a valid/ready pop side.
// Transmit words are pulled one per word from a valid/ready source. When no
// word is offered, the slave sends IDLE_TX instead.
module spi_slave_stream #(
    parameter int                DATA_W     = 4,
    parameter int                FIFO_DEPTH = 4,
    parameter bit                CPOL       = 1'b0,
    parameter bit                CPHA       = 1'b0,
    parameter bit                MSB_FIRST  = 1'b1,
    parameter logic [DATA_W-1:0] IDLE_TX    = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sclk_in,
    input  logic                          mosi_in,
    input  logic                          ss_n_in,
    output logic                          miso_out,
    output logic [DATA_W-1:0]             rx_data_out,
    output logic                          rx_valid_out,
    input  logic                          rx_ready_in,
    input  logic [DATA_W-1:0]             tx_data_in,
    input  logic                          tx_valid_in,
    output logic                          tx_ready_out,
    output logic                          frame_active_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
    output logic                          overflow_out,
    output logic                          frame_err_out,
    input  logic                          clear_err_in
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    // Synchroniser chains; sync3 holds the previous value for edge detection.
    logic sclk_sync1_reg, sclk_sync2_reg, sclk_sync3_reg;
    logic ss_sync1_reg, ss_sync2_reg, ss_sync3_reg;
    logic mosi_sync1_reg, mosi_sync2_reg;

    state_t            state_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [DATA_W-1:0] rx_shift_reg;
    logic [DATA_W-1:0] tx_shift_reg;
    logic              load_pending_reg;
    logic              miso_reg;
    logic              frame_active_reg;
    logic              frame_err_reg;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic              overflow_reg;

    // Decoded SPI events, valid for the one cycle after sync2 changes.
    logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic ss_fall, ss_rise;
    logic [DATA_W-1:0] tx_load_word, tx_shifted, rx_shifted;
    logic load_first_bit, shift_first_bit;
    logic load_now, push_now, push_ok, pop_now, fifo_full;

    assign sclk_edge   = sclk_sync2_reg ^ sclk_sync3_reg;
    assign lead_edge   = sclk_edge & (sclk_sync2_reg != CPOL);
    assign trail_edge  = sclk_edge & (sclk_sync2_reg == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign ss_fall     = ss_sync3_reg & ~ss_sync2_reg;
    assign ss_rise     = ~ss_sync3_reg & ss_sync2_reg;

    assign tx_load_word    = tx_valid_in ? tx_data_in : IDLE_TX;
    assign tx_shifted      = MSB_FIRST ? {tx_shift_reg[DATA_W-2:0], 1'b0}
                                       : {1'b0, tx_shift_reg[DATA_W-1:1]};
    assign rx_shifted      = MSB_FIRST ? {rx_shift_reg[DATA_W-2:0], mosi_sync2_reg}
                                       : {mosi_sync2_reg, rx_shift_reg[DATA_W-1:1]};
    assign load_first_bit  = MSB_FIRST ? tx_load_word[DATA_W-1] : tx_load_word[0];
    assign shift_first_bit = MSB_FIRST ? tx_shifted[DATA_W-1] : tx_shifted[0];

    // A TX load happens on frame entry (CPHA=0) or on the first shift edge
    // after a completed word; the source handshake is only offered then.
    assign load_now = reset &&
                      (((state_reg == IDLE) && ss_fall && !CPHA) ||
                       ((state_reg == ACTIVE) && !ss_rise && shift_edge && load_pending_reg));
    assign tx_ready_out = load_now & tx_valid_in;

    assign push_now  = reset && (state_reg == ACTIVE) && !ss_rise && sample_edge &&
                       (bit_cnt_reg == LAST_BIT);
    assign fifo_full = (level_reg == FULL_LVL);
    assign pop_now   = rx_valid_out & rx_ready_in;
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign push_ok   = push_now & (~fifo_full | pop_now);

    assign rx_valid_out     = (level_reg != '0);
    assign rx_data_out      = rx_valid_out ? fifo_mem[rd_ptr_reg] : '0;
    assign fifo_level_out   = level_reg;
    assign overflow_out     = overflow_reg;
    assign frame_err_out    = frame_err_reg;
    assign miso_out         = miso_reg;
    assign frame_active_out = frame_active_reg;

    // Bring the asynchronous SPI pins into the clk domain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sclk_sync1_reg <= CPOL;
            sclk_sync2_reg <= CPOL;
            sclk_sync3_reg <= CPOL;
            ss_sync1_reg   <= 1'b1;
            ss_sync2_reg   <= 1'b1;
            ss_sync3_reg   <= 1'b1;
            mosi_sync1_reg <= 1'b0;
            mosi_sync2_reg <= 1'b0;
        end else begin
            sclk_sync1_reg <= sclk_in;
            sclk_sync2_reg <= sclk_sync1_reg;
            sclk_sync3_reg <= sclk_sync2_reg;
            ss_sync1_reg   <= ss_n_in;
            ss_sync2_reg   <= ss_sync1_reg;
            ss_sync3_reg   <= ss_sync2_reg;
            mosi_sync1_reg <= mosi_in;
            mosi_sync2_reg <= mosi_sync1_reg;
        end
    end

    // Frame FSM: bit counting, RX/TX shifting, MISO and framing error flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg        <= IDLE;
            bit_cnt_reg      <= '0;
            rx_shift_reg     <= '0;
            tx_shift_reg     <= '0;
            load_pending_reg <= 1'b0;
            miso_reg         <= 1'b0;
            frame_active_reg <= 1'b0;
            frame_err_reg    <= 1'b0;
        end else begin
            // Clear first so a same-cycle set below takes priority.
            if (clear_err_in) begin
                frame_err_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (ss_fall) begin
                        state_reg        <= ACTIVE;
                        frame_active_reg <= 1'b1;
                        bit_cnt_reg      <= '0;
                        rx_shift_reg     <= '0;
                        load_pending_reg <= CPHA;
                        if (!CPHA) begin
                            tx_shift_reg <= tx_load_word;
                            miso_reg     <= load_first_bit;
                        end else begin
                            miso_reg     <= 1'b0;
                        end
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        state_reg        <= IDLE;
                        frame_active_reg <= 1'b0;
                        miso_reg         <= 1'b0;
                        if (bit_cnt_reg != '0) begin
                            frame_err_reg <= 1'b1;
                        end
                    end else if (sample_edge) begin
                        rx_shift_reg <= rx_shifted;
                        if (bit_cnt_reg == LAST_BIT) begin
                            bit_cnt_reg      <= '0;
                            load_pending_reg <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end else if (shift_edge) begin
                        if (load_pending_reg) begin
                            tx_shift_reg     <= tx_load_word;
                            miso_reg         <= load_first_bit;
                            load_pending_reg <= 1'b0;
                        end else begin
                            tx_shift_reg <= tx_shifted;
                            miso_reg     <= shift_first_bit;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // FIFO pointers, level and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_now) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_now})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
            if (push_now && fifo_full && !pop_now) begin
                overflow_reg <= 1'b1;
            end else if (clear_err_in) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // FIFO storage; contents need no reset because the level gates the read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= rx_shifted;
        end
    end

endmodule

// File: tb/tb_spi_slave_stream.sv
// Testbench for spi_slave_stream. Eight instances cover every CPOL/CPHA and
// bit-order combination (index m: CPOL=m%2, CPHA=(m/2)%2, MSB first when m<4),
// all with DATA_W=4, FIFO_DEPTH=4 and IDLE_TX=0x6. A bus-functional SPI master
// and a word-level reference model drive and check the selected instance.
`timescale 1ns/1ps
module tb_spi_slave_stream;

    localparam int N     = 8;
    localparam int HALF  = 6;
    localparam int SETUP = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       sclk [N];
    logic       mosi [N];
    logic       ss_n [N];
    logic       miso [N];
    logic [3:0] rx_data [N];
    logic       rx_valid [N];
    logic       rx_ready [N];
    logic [3:0] tx_data [N];
    logic       tx_valid [N];
    logic       tx_ready [N];
    logic       frame_active [N];
    logic [2:0] fifo_level [N];
    logic       overflow [N];
    logic       frame_err [N];
    logic       clear_err [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        spi_slave_stream #(
            .DATA_W    (4),
            .FIFO_DEPTH(4),
            .CPOL      ((gi % 2) == 1),
            .CPHA      (((gi / 2) % 2) == 1),
            .MSB_FIRST (gi < 4),
            .IDLE_TX   (4'h6)
        ) u_dut (
            .clk             (clk),
            .reset           (reset),
            .sclk_in         (sclk[gi]),
            .mosi_in         (mosi[gi]),
            .ss_n_in         (ss_n[gi]),
            .miso_out        (miso[gi]),
            .rx_data_out     (rx_data[gi]),
            .rx_valid_out    (rx_valid[gi]),
            .rx_ready_in     (rx_ready[gi]),
            .tx_data_in      (tx_data[gi]),
            .tx_valid_in     (tx_valid[gi]),
            .tx_ready_out    (tx_ready[gi]),
            .frame_active_out(frame_active[gi]),
            .fifo_level_out  (fifo_level[gi]),
            .overflow_out    (overflow[gi]),
            .frame_err_out   (frame_err[gi]),
            .clear_err_in    (clear_err[gi])
        );
    end

    int         cur;
    int         n_checks;
    int         n_fail;
    int         tx_pulses;
    bit         active_seen;
    logic [3:0] tx_q [$];
    logic [3:0] tx_off [$];
    logic [3:0] rx_got [$];
    logic [3:0] fw [$];
    logic       miso_bits [$];

    // Present the head of the TX queue to the selected instance.
    task automatic tx_present();
        tx_valid[cur] = (tx_q.size() != 0);
        tx_data[cur]  = (tx_q.size() != 0) ? tx_q[0] : 4'h0;
    endtask

    // One clk cycle: observe at negedge, update drive 1ns after posedge.
    task automatic tick();
        bit took;
        @(negedge clk);
        if (rx_valid[cur] === 1'b1 && rx_ready[cur] === 1'b1) rx_got.push_back(rx_data[cur]);
        took = (tx_ready[cur] === 1'b1);
        if (took) tx_pulses++;
        if (frame_active[cur] === 1'b1) active_seen = 1'b1;
        @(posedge clk);
        #1;
        if (took && tx_q.size() > 0) void'(tx_q.pop_front());
        tx_present();
    endtask

    // SPI master: clocks nbits of fw on instance m, capturing MISO at each
    // sample edge. pop_last pulses rx_ready for the single cycle in which the
    // last word is pushed; keep_open leaves SS_n low at the end.
    task automatic spi_frame(input int m, input int nbits, input bit keep_open, input bit pop_last);
        bit cpol, cpha, msb;
        cpol = (m % 2) == 1;
        cpha = ((m / 2) % 2) == 1;
        msb  = (m < 4);
        miso_bits.delete();
        active_seen = 1'b0;
        tx_present();
        ss_n[m] = 1'b0;
        repeat (SETUP) tick();
        for (int b = 0; b < nbits; b++) begin
            logic [3:0] w;
            int         bi;
            bit         last;
            w    = fw[b / 4];
            bi   = msb ? 3 - (b % 4) : (b % 4);
            last = (b == nbits - 1);
            if (!cpha) begin
                mosi[m] = w[bi];
                repeat (HALF) tick();
                miso_bits.push_back(miso[m]);
                sclk[m] = ~cpol;
            end else begin
                sclk[m] = ~cpol;
                mosi[m] = w[bi];
                repeat (HALF) tick();
                miso_bits.push_back(miso[m]);
                sclk[m] = cpol;
            end
            for (int t = 0; t < HALF; t++) begin
                if (pop_last && last && t == 2) rx_ready[m] = 1'b1;
                tick();
                if (pop_last && last && t == 2) rx_ready[m] = 1'b0;
            end
            if (!cpha) begin
                sclk[m] = cpol;
                repeat (HALF) tick();
            end
        end
        if (!keep_open) begin
            repeat (SETUP) tick();
            ss_n[m] = 1'b1;
            mosi[m] = 1'b0;
            repeat (SETUP) tick();
        end
        $display("frame: inst=%0d bits=%0d rx_words=%0d tx_pulses=%0d level=%0d",
                 m, nbits, rx_got.size(), tx_pulses, fifo_level[m]);
    endtask

    // Reference MISO stream: word slot i carries the i-th offered TX word,
    // or IDLE_TX once the offers run out, serialised in the instance's bit order.
    function automatic logic [63:0] exp_miso(input int m, input int nbits);
        logic [63:0] acc;
        logic [3:0]  slot;
        int          pos;
        acc = '0;
        for (int b = 0; b < nbits; b++) begin
            slot = ((b / 4) < tx_off.size()) ? tx_off[b / 4] : 4'h6;
            pos  = (m < 4) ? 3 - (b % 4) : (b % 4);
            acc  = {acc[62:0], slot[pos]};
        end
        return acc;
    endfunction

    function automatic logic [63:0] got_miso();
        logic [63:0] acc;
        acc = '0;
        foreach (miso_bits[i]) acc = {acc[62:0], miso_bits[i]};
        return acc;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if ({miso[i], rx_valid[i], tx_ready[i], frame_active[i], overflow[i], frame_err[i]} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_flags inst=%0d: got %b expected 000000", i,
                         {miso[i], rx_valid[i], tx_ready[i], frame_active[i], overflow[i], frame_err[i]});
            end
            n_checks++;
            if ({rx_data[i], fifo_level[i]} !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_data inst=%0d: got data=%h level=%0d expected 0/0", i, rx_data[i], fifo_level[i]);
            end
        end
        reset = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_stream();
        logic [3:0] exp_rx [3];
        exp_rx = '{4'hA, 4'h5, 4'hC};
        cur = 0;
        rx_ready[0] = 1'b1;
        rx_got.delete();
        tx_pulses = 0;
        tx_q.delete();
        tx_q.push_back(4'h3); tx_q.push_back(4'h9); tx_q.push_back(4'h6);
        fw.delete();
        fw.push_back(4'hA); fw.push_back(4'h5); fw.push_back(4'hC);
        spi_frame(0, 12, 1'b0, 1'b0);
        rx_ready[0] = 1'b0;
        n_checks++;
        if (rx_got.size() !== 3) begin
            n_fail++;
            $display("FAIL stream_rx_count: got %0d expected 3", rx_got.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (((i < rx_got.size()) ? rx_got[i] : 4'hx) !== exp_rx[i]) begin
                n_fail++;
                $display("FAIL stream_rx_word%0d: got %h expected %h", i,
                         (i < rx_got.size()) ? rx_got[i] : 4'hx, exp_rx[i]);
            end
        end
        n_checks++;
        if (got_miso() !== 64'h396) begin
            n_fail++;
            $display("FAIL stream_miso: got %h expected 396", got_miso());
        end
        n_checks++;
        if (tx_pulses !== 3) begin
            n_fail++;
            $display("FAIL stream_tx_pulses: got %0d expected 3", tx_pulses);
        end
        n_checks++;
        if (active_seen !== 1'b1 || frame_active[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_frame_active: seen=%b after=%b expected 1/0", active_seen, frame_active[0]);
        end
        n_checks++;
        if ({overflow[0], frame_err[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL stream_flags: got %b expected 00", {overflow[0], frame_err[0]});
        end
    endtask

    task automatic test_modes();
        for (int m = 0; m < N; m++) begin
            cur = m;
            rx_ready[m] = 1'b1;
            rx_got.delete();
            tx_q.delete();
            tx_off.delete();
            tx_pulses = 0;
            fw.delete();
            fw.push_back(4'h9);
            spi_frame(m, 4, 1'b0, 1'b0);
            rx_ready[m] = 1'b0;
            n_checks++;
            if (rx_got.size() !== 1 || rx_got[0] !== 4'h9) begin
                n_fail++;
                $display("FAIL modes_rx inst=%0d: got %0d words first=%h expected 1 word 9", m,
                         rx_got.size(), (rx_got.size() > 0) ? rx_got[0] : 4'hx);
            end
            n_checks++;
            if (got_miso() !== exp_miso(m, 4)) begin
                n_fail++;
                $display("FAIL modes_miso inst=%0d: got %h expected %h", m, got_miso(), exp_miso(m, 4));
            end
            n_checks++;
            if (tx_pulses !== 0) begin
                n_fail++;
                $display("FAIL modes_tx_pulses inst=%0d: got %0d expected 0", m, tx_pulses);
            end
        end
    endtask

    task automatic test_random_frames();
        for (int it = 0; it < 16; it++) begin
            int m, nw, noff;
            m    = $urandom_range(0, N - 1);
            nw   = $urandom_range(1, 3);
            noff = $urandom_range(0, nw);
            cur  = m;
            rx_ready[m] = 1'b1;
            rx_got.delete();
            tx_q.delete();
            tx_off.delete();
            fw.delete();
            tx_pulses = 0;
            for (int i = 0; i < nw; i++) fw.push_back(4'($urandom));
            for (int i = 0; i < noff; i++) tx_off.push_back(4'($urandom));
            tx_q = tx_off;
            spi_frame(m, 4 * nw, 1'b0, 1'b0);
            rx_ready[m] = 1'b0;
            n_checks++;
            if (rx_got !== fw) begin
                n_fail++;
                $display("FAIL random_rx it=%0d inst=%0d: got %0d words first=%h expected %0d words first=%h",
                         it, m, rx_got.size(), (rx_got.size() > 0) ? rx_got[0] : 4'hx, fw.size(), fw[0]);
            end
            n_checks++;
            if (got_miso() !== exp_miso(m, 4 * nw)) begin
                n_fail++;
                $display("FAIL random_miso it=%0d inst=%0d: got %h expected %h", it, m, got_miso(), exp_miso(m, 4 * nw));
            end
            n_checks++;
            if (tx_pulses !== noff) begin
                n_fail++;
                $display("FAIL random_tx_pulses it=%0d inst=%0d: got %0d expected %0d", it, m, tx_pulses, noff);
            end
        end
    endtask

    task automatic test_overflow();
        logic [3:0] fill [$];
        logic [3:0] exp_q [$];
        cur = 0;
        tx_q.delete();
        rx_ready[0] = 1'b0;
        fw.delete();
        for (int i = 0; i < 6; i++) fw.push_back(4'($urandom));
        spi_frame(0, 24, 1'b0, 1'b0);
        n_checks++;
        if (fifo_level[0] !== 3'd4 || overflow[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_full: got level=%0d overflow=%b expected 4/1", fifo_level[0], overflow[0]);
        end
        n_checks++;
        if (rx_valid[0] !== 1'b1 || rx_data[0] !== fw[0]) begin
            n_fail++;
            $display("FAIL ovf_head: got valid=%b data=%h expected 1/%h", rx_valid[0], rx_data[0], fw[0]);
        end
        rx_got.delete();
        rx_ready[0] = 1'b1;
        repeat (6) tick();
        rx_ready[0] = 1'b0;
        exp_q = fw[0:3];
        n_checks++;
        if (rx_got !== exp_q) begin
            n_fail++;
            $display("FAIL ovf_pops: got %0d words first=%h expected 4 words first=%h",
                     rx_got.size(), (rx_got.size() > 0) ? rx_got[0] : 4'hx, exp_q[0]);
        end
        n_checks++;
        if (fifo_level[0] !== 3'd0 || rx_valid[0] !== 1'b0 || rx_data[0] !== 4'h0) begin
            n_fail++;
            $display("FAIL ovf_empty: got level=%0d valid=%b data=%h expected 0/0/0", fifo_level[0], rx_valid[0], rx_data[0]);
        end
        n_checks++;
        if (overflow[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b expected 1", overflow[0]);
        end
        clear_err[0] = 1'b1;
        tick();
        clear_err[0] = 1'b0;
        n_checks++;
        if (overflow[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b expected 0", overflow[0]);
        end
        // Fill exactly, then push one more while the head pops in the same cycle.
        fw.delete();
        for (int i = 0; i < 4; i++) fw.push_back(4'($urandom));
        fill = fw;
        spi_frame(0, 16, 1'b0, 1'b0);
        fw.delete();
        fw.push_back(4'($urandom));
        rx_got.delete();
        spi_frame(0, 4, 1'b0, 1'b1);
        n_checks++;
        if (fifo_level[0] !== 3'd4 || overflow[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_pushpop: got level=%0d overflow=%b expected 4/0", fifo_level[0], overflow[0]);
        end
        n_checks++;
        if (rx_got.size() !== 1 || rx_got[0] !== fill[0]) begin
            n_fail++;
            $display("FAIL ovf_pushpop_head: got %0d words first=%h expected 1 word %h",
                     rx_got.size(), (rx_got.size() > 0) ? rx_got[0] : 4'hx, fill[0]);
        end
        exp_q = fill[1:3];
        exp_q.push_back(fw[0]);
        rx_got.delete();
        rx_ready[0] = 1'b1;
        repeat (6) tick();
        rx_ready[0] = 1'b0;
        n_checks++;
        if (rx_got !== exp_q) begin
            n_fail++;
            $display("FAIL ovf_pushpop_drain: got %0d words last=%h expected 4 words last=%h",
                     rx_got.size(), (rx_got.size() > 0) ? rx_got[rx_got.size() - 1] : 4'hx, exp_q[3]);
        end
    endtask

    task automatic test_frame_err();
        cur = 0;
        tx_q.delete();
        rx_ready[0] = 1'b1;
        rx_got.delete();
        fw.delete();
        fw.push_back(4'($urandom));
        spi_frame(0, 2, 1'b0, 1'b0);
        n_checks++;
        if (frame_err[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ferr_set: got %b expected 1", frame_err[0]);
        end
        n_checks++;
        if (rx_got.size() !== 0 || fifo_level[0] !== 3'd0) begin
            n_fail++;
            $display("FAIL ferr_no_push: got words=%0d level=%0d expected 0/0", rx_got.size(), fifo_level[0]);
        end
        fw.delete();
        fw.push_back(4'hF);
        spi_frame(0, 4, 1'b0, 1'b0);
        n_checks++;
        if (rx_got.size() !== 1 || rx_got[0] !== 4'hF) begin
            n_fail++;
            $display("FAIL ferr_next_frame: got %0d words first=%h expected 1 word f",
                     rx_got.size(), (rx_got.size() > 0) ? rx_got[0] : 4'hx);
        end
        n_checks++;
        if (frame_err[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ferr_sticky: got %b expected 1", frame_err[0]);
        end
        clear_err[0] = 1'b1;
        tick();
        clear_err[0] = 1'b0;
        rx_ready[0] = 1'b0;
        n_checks++;
        if (frame_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_clear: got %b expected 0", frame_err[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        cur = 0;
        tx_q.delete();
        rx_ready[0] = 1'b0;
        fw.delete();
        for (int i = 0; i < 3; i++) fw.push_back(4'($urandom));
        spi_frame(0, 10, 1'b1, 1'b0);
        n_checks++;
        if (fifo_level[0] !== 3'd2 || frame_active[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_before: got level=%0d active=%b expected 2/1", fifo_level[0], frame_active[0]);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({miso[0], rx_valid[0], tx_ready[0], frame_active[0], overflow[0], frame_err[0]} !== 6'b0 ||
            rx_data[0] !== 4'h0 || fifo_level[0] !== 3'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got flags=%b data=%h level=%0d expected 000000/0/0",
                     {miso[0], rx_valid[0], tx_ready[0], frame_active[0], overflow[0], frame_err[0]},
                     rx_data[0], fifo_level[0]);
        end
        ss_n[0] = 1'b1;
        mosi[0] = 1'b0;
        sclk[0] = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        repeat (4) tick();
        rx_got.delete();
        rx_ready[0] = 1'b1;
        fw.delete();
        fw.push_back(4'h7);
        spi_frame(0, 4, 1'b0, 1'b0);
        rx_ready[0] = 1'b0;
        n_checks++;
        if (rx_got.size() !== 1 || rx_got[0] !== 4'h7 || frame_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_recover: got %0d words first=%h ferr=%b expected 1 word 7 ferr 0",
                     rx_got.size(), (rx_got.size() > 0) ? rx_got[0] : 4'hx, frame_err[0]);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        tx_pulses = 0;
        cur       = 0;
        reset     = 1'b0;
        for (int i = 0; i < N; i++) begin
            sclk[i]      = (i % 2) == 1;
            mosi[i]      = 1'b0;
            ss_n[i]      = 1'b1;
            rx_ready[i]  = 1'b0;
            tx_data[i]   = 4'h0;
            tx_valid[i]  = 1'b0;
            clear_err[i] = 1'b0;
        end
        test_reset();
        test_stream();
        test_modes();
        test_random_frames();
        test_overflow();
        test_frame_err();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
